// File: rtl/mdu_unit.sv
// Purpose : multi-cycle multiply/divide unit with HI/LO registers and mfhi/mflo read port.
// Latency : mult/multu commit MULT_CYCLES edges after accept, div/divu DIV_CYCLES; mthi/mtlo next edge.
// Backpr. : Busy high while an op is in flight; MDU ops presented during Busy are dropped (issue must stall).
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   MDUControl[3:0]     0 nop, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo
//   A, B [WIDTH]        rs / rt operands
//   Start, Busy         op accepted this cycle / op in flight
//   HI, LO [WIDTH]      architectural HI/LO registers
//   MDUOut [WIDTH]      HI for mfhi, LO for mflo, else 0
// Build option:
//   MDU_DIV0_HOLD_EN    when defined, divide by zero leaves HI/LO untouched;
//                       otherwise it commits LO = all ones, HI = dividend.
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       MDUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Start,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] MDUOut
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic [CNT_W-1:0]        cnt_q;
    logic [WIDTH-1:0]        a_q, b_q;
    logic [3:0]              op_q;
    logic [WIDTH-1:0]        hi_q, lo_q;

    logic [2*WIDTH-1:0]      prod_s, prod_u;
    logic                    b_zero, b_neg_one;
    logic [WIDTH-1:0]        divisor;
    logic signed [WIDTH-1:0] a_s, b_s, quo_s, rem_s;
    logic [WIDTH-1:0]        quo_u, rem_u;

    logic                    res_wr;
    logic [WIDTH-1:0]        res_hi, res_lo;

    assign Busy  = (cnt_q != '0);
    assign Start = (MDUControl >= OP_MULT) && (MDUControl <= OP_DIVU) && !Busy;
    assign HI    = hi_q;
    assign LO    = lo_q;

    always_comb begin
        MDUOut = '0;
        if (MDUControl == OP_MFHI) MDUOut = hi_q;
        else if (MDUControl == OP_MFLO) MDUOut = lo_q;
    end

    // Result is computed in one shot from the latched operands; the counter only
    // delays the commit, so the operands must stay frozen for the whole busy window.
    assign prod_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
    assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

    assign b_zero    = (b_q == '0);
    assign b_neg_one = &b_q;
    // Substitute 1 for a zero divisor so the dividers never see x/0; the
    // zero case is overridden in the result mux anyway.
    assign divisor   = b_zero ? WIDTH'(1) : b_q;
    assign a_s       = a_q;
    assign b_s       = divisor;
    assign quo_u     = a_q / divisor;
    assign rem_u     = a_q % divisor;

    // Divide by -1 is negation; handling it here makes MIN/-1 wrap to MIN
    // with remainder 0 instead of relying on overflow behaviour of '/'.
    always_comb begin
        quo_s = '0;
        rem_s = '0;
        if (b_neg_one) begin
            quo_s = '0 - a_s;
            rem_s = '0;
        end else begin
            quo_s = a_s / b_s;
            rem_s = a_s % b_s;
        end
    end

    always_comb begin
        res_wr = 1'b1;
        res_hi = hi_q;
        res_lo = lo_q;
        case (op_q)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV, OP_DIVU: begin
                if (b_zero) begin
`ifdef MDU_DIV0_HOLD_EN
                    res_wr = 1'b0;
`else
                    res_hi = a_q;
                    res_lo = '1;
`endif
                end else if (op_q == OP_DIV) begin
                    res_hi = rem_s;
                    res_lo = quo_s;
                end else begin
                    res_hi = rem_u;
                    res_lo = quo_u;
                end
            end
            default:  res_wr = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else if (Busy) begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1) && res_wr) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end else begin
            case (MDUControl)
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                    a_q   <= A;
                    b_q   <= B;
                    op_q  <= MDUControl;
                    cnt_q <= (MDUControl == OP_MULT || MDUControl == OP_MULTU)
                             ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                end
                OP_MTHI: hi_q <= A;
                OP_MTLO: lo_q <= A;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Purpose : directed checks of mdu_unit (default 32-bit, 5/10 cycle latencies).
// Latency : n/a (bench).
// Backpr. : n/a (bench).
module tb_mdu_unit;

    localparam int NM = 5;
    localparam int ND = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  MDUControl;
    logic [31:0] A, B;
    logic        Start, Busy;
    logic [31:0] HI, LO, MDUOut;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_hi, exp_lo;

    mdu_unit #(.WIDTH(32), .MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk(clk), .reset(reset), .MDUControl(MDUControl), .A(A), .B(B),
        .Start(Start), .Busy(Busy), .HI(HI), .LO(LO), .MDUOut(MDUOut)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Present an MDU op while idle, confirm Start, let it be accepted, return to nop.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        MDUControl = op;
        A = a;
        B = b;
        #1;
        chk("start_on_issue", {31'b0, Start}, 32'd1);
        chk("idle_on_issue", {31'b0, Busy}, 32'd0);
        tick();
        MDUControl = 4'd0;
    endtask

    // Walk the busy window with 'ctl' presented; HI/LO must hold the given old
    // values for exactly n cycles, then the caller checks the commit.
    task automatic wait_busy(input int n, input logic [3:0] ctl,
                             input logic [31:0] hi_old, input logic [31:0] lo_old);
        for (int i = 0; i < n; i++) begin
            MDUControl = ctl;
            #1;
            chk("busy_window", {31'b0, Busy}, 32'd1);
            chk("no_start_busy", {31'b0, Start}, 32'd0);
            chk("hi_hold", HI, hi_old);
            chk("lo_hold", LO, lo_old);
            if (ctl == 4'd6) chk("mflo_stale", MDUOut, lo_old);
            tick();
        end
        #1;
        chk("busy_fall", {31'b0, Busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        MDUControl = 4'd0;
        A = '0;
        B = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_busy", {31'b0, Busy}, 32'd0);
        chk("rst_start", {31'b0, Start}, 32'd0);
        chk("rst_mduout", MDUOut, 32'd0);

        // mult -3 * 7
        issue(4'd1, 32'hFFFF_FFFD, 32'd7);
        wait_busy(NM, 4'd0, 32'd0, 32'd0);
        chk("mult_hi", HI, 32'hFFFF_FFFF);
        chk("mult_lo", LO, 32'hFFFF_FFEB);

        // divu 100 / 7
        issue(4'd4, 32'd100, 32'd7);
        wait_busy(ND, 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        chk("divu_lo", LO, 32'd14);
        chk("divu_hi", HI, 32'd2);

        // div -7 / 2
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        wait_busy(ND, 4'd0, 32'd2, 32'd14);
        chk("div_neg_lo", LO, 32'hFFFF_FFFD);
        chk("div_neg_hi", HI, 32'hFFFF_FFFF);

        // div MIN / -1 wraps
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_busy(ND, 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        chk("div_min_lo", LO, 32'h8000_0000);
        chk("div_min_hi", HI, 32'd0);

        // div 5 / 0, then divu 7 / 0
`ifdef MDU_DIV0_HOLD_EN
        exp_hi = 32'd0;
        exp_lo = 32'h8000_0000;
`else
        exp_hi = 32'd5;
        exp_lo = 32'hFFFF_FFFF;
`endif
        issue(4'd3, 32'd5, 32'd0);
        wait_busy(ND, 4'd0, 32'd0, 32'h8000_0000);
        chk("div0_hi", HI, exp_hi);
        chk("div0_lo", LO, exp_lo);
        issue(4'd4, 32'd7, 32'd0);
        wait_busy(ND, 4'd0, exp_hi, exp_lo);
`ifndef MDU_DIV0_HOLD_EN
        exp_hi = 32'd7;
`endif
        chk("divu0_hi", HI, exp_hi);
        chk("divu0_lo", LO, exp_lo);

        // mult -1 * 1 with mthi 9 presented throughout the busy window
        issue(4'd1, 32'hFFFF_FFFF, 32'd1);
        A = 32'd9;
        wait_busy(NM, 4'd7, exp_hi, exp_lo);
        MDUControl = 4'd0;
        chk("mthi_busy_hi", HI, 32'hFFFF_FFFF);
        chk("mthi_busy_lo", LO, 32'hFFFF_FFFF);

        // mthi / mtlo while idle
        MDUControl = 4'd7;
        A = 32'd9;
        #1;
        chk("mthi_no_start", {31'b0, Start}, 32'd0);
        tick();
        chk("mthi_idle_hi", HI, 32'd9);
        chk("mthi_no_busy", {31'b0, Busy}, 32'd0);
        MDUControl = 4'd8;
        A = 32'h33;
        tick();
        chk("mtlo_idle_lo", LO, 32'h33);
        chk("mtlo_hi_keep", HI, 32'd9);

        // codes 9..15 change nothing and read as 0
        MDUControl = 4'd9;
        A = 32'h55;
        #1;
        chk("code9_out", MDUOut, 32'd0);
        chk("code9_start", {31'b0, Start}, 32'd0);
        MDUControl = 4'd15;
        tick();
        chk("code15_hi", HI, 32'd9);
        chk("code15_lo", LO, 32'h33);
        chk("code15_busy", {31'b0, Busy}, 32'd0);
        MDUControl = 4'd0;

        // mult 2*3 aborted by reset in busy cycle 2
        issue(4'd1, 32'd2, 32'd3);
        tick();
        chk("abort_busy_pre", {31'b0, Busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        chk("abort_busy", {31'b0, Busy}, 32'd0);
        for (int i = 0; i < NM + 2; i++) tick();
        chk("abort_no_commit_hi", HI, 32'd0);
        chk("abort_no_commit_lo", LO, 32'd0);

        // multu 0xFFFFFFFF * 2, then divu 9 / 4 issued the first idle cycle
        issue(4'd2, 32'hFFFF_FFFF, 32'd2);
        wait_busy(NM, 4'd6, 32'd0, 32'd0);
        chk("multu_hi", HI, 32'd1);
        chk("multu_lo", LO, 32'hFFFF_FFFE);
        chk("multu_mflo", MDUOut, 32'hFFFF_FFFE);
        issue(4'd4, 32'd9, 32'd4);
        wait_busy(ND, 4'd6, 32'd1, 32'hFFFF_FFFE);
        chk("b2b_lo", LO, 32'd2);
        chk("b2b_hi", HI, 32'd1);
        chk("b2b_mflo", MDUOut, 32'd2);
        MDUControl = 4'd5;
        #1;
        chk("b2b_mfhi", MDUOut, 32'd1);
        MDUControl = 4'd0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
